subpel_hfilter_engine: RTL and testbench
========================================

// Module: subpel_hfilter_engine
// PURPOSE
//  Parametrised horizontal HEVC luma sub-pixel filter engine for one prediction block.
//  Accepts BLK_H+7 reference rows of NUM_PIXEL+7 pixels over a valid/ready stream.
//  Emits the quarter (A), half (B) and three-quarter (C) horizontal samples per row.
//  Feeds the vertical-pass buffers; replaces the fixed 8x8 free-running counter control
//  with an FSM, backpressure and block framing.
// PARAMETERS
//  NUM_PIXEL  8   output pixels per row (block width)
//  BLK_H      8   output block height; rows consumed per block = BLK_H+7
//  PIXEL_W    8   input sample width in bits
// PORTS
//  clk          in   1                    clock
//  rst          in   1                    asynchronous, active-low reset
//  start        in   1                    pulse: begin a new block (honoured in IDLE only)
//  in_valid     in   1                    in_row valid
//  in_ready     out  1                    engine accepts in_row this cycle
//  in_row       in   (NUM_PIXEL+7)*PIXEL_W  pixel k at [k*PIXEL_W +: PIXEL_W]
//  out_valid    out  1                    out_row_* valid
//  out_ready    in   1                    downstream accepts
//  out_row_a    out  NUM_PIXEL*OUT_W      quarter-pel samples, pixel i at [i*OUT_W +: OUT_W]
//  out_row_b    out  NUM_PIXEL*OUT_W      half-pel samples
//  out_row_c    out  NUM_PIXEL*OUT_W      three-quarter-pel samples
//  out_row_idx  out  8                    index 0..BLK_H+6 of the row being output
//  out_last     out  1                    qualifies the final row of the block
//  busy         out  1                    state != IDLE
//  done         out  1                    one-cycle pulse after the last row is accepted
// BEHAVIOUR
//  Reset: state=IDLE; all valids, out_last, done, busy = 0; data/idx regs = 0. Reset mid-block aborts it.
//  FSM:
//   - IDLE --start--> LOAD.
//   - LOAD: after accepting row BLK_H+6 --> DRAIN.
//   - DRAIN: last row accepted at output --> IDLE, with done=1 that cycle (registered pulse, next cycle).
//   - start in LOAD/DRAIN is ignored.
//  Pipeline: 2 stages.
//   - S1 registers per-tap products.
//   - S2 sums, rounds and clips into the output regs.
//   - Advance enable en = !out_valid || out_ready.
//   - in_ready = (state==LOAD) && en.
//   - Accept at cycle t -> out_valid at t+2 when no stall. Stall holds all stages; no data loss or duplication.
//  Filter for pixel i:
//   - Uses window in_row pixels i..i+7.
//   - Coefficients: A={-1,4,-10,58,17,-5,1,0}, B={-1,4,-11,40,40,-11,4,-1}, C={0,1,-5,17,58,-10,4,-1} (tap0 first).
//   - Signed sum width PIXEL_W+8.
//   - Default output: (sum+32)>>>6, clipped to [0, 2^PIXEL_W-1]; OUT_W=PIXEL_W.
//  Row index: idx counter increments per accepted input row and travels with the data.
//   - out_last = (out_row_idx==BLK_H+6).
//   - The counter clears on entering LOAD.
//  in_valid in IDLE/DRAIN: not accepted (in_ready=0); data held by source.
// CONFIGURATION
//  SUBPEL_HI_PREC_EN defined:
//   - OUT_W=16; outputs are the raw signed sum >>> (PIXEL_W-8), no rounding, no clip.
//   - This is the HEVC intermediate for the vertical pass.
//  Undefined: OUT_W=PIXEL_W, rounded and clipped as above.
// STRUCTURE
//  Package hevc_subpel_pkg holds:
//   - coefficient tables COEF_A/B/C;
//   - FSM state encodings S_IDLE/S_LOAD/S_DRAIN;
//   - constants ROUND=32, SHIFT=6;
//   - function clip_pix.
//  Sub-module subpel_fir8:
//   - One window to A/B/C, with S1/S2 regs and shared enable.
//   - Instantiated NUM_PIXEL times by generate.
//   - Top holds the FSM, counters and handshake.
// TESTING
//  1. Reset, start, 15 rows of all 100, out_ready=1
//     -> 15 outputs, every A/B/C=100, idx 0..14, out_last on idx 14, done 1 cycle later.
//  2. Window 255 at taps 1,3,4,6, else 0
//     -> A=255 (clip, sum 20400); window 255 at taps 0,2,5 -> A=0 (sum -4080).
//  3. out_ready low 5 cycles mid-block with in_valid high
//     -> in_ready=0 while full, outputs held stable, no row lost or repeated.
//  4. start asserted during LOAD and DRAIN -> ignored; start in the cycle after done -> new block, idx restarts at 0.
//  5. rst asserted after row 6 -> all outputs 0 at once, IDLE; next start runs a full correct block.
//  6. SUBPEL_HI_PREC_EN, B window {0,0,0,255,255,0,0,0} -> out_row_b=20400 unclipped.

Source files
------------

// File: rtl/hevc_subpel_pkg.sv
// Shared constants for the horizontal HEVC luma sub-pel filter: tap tables,
// FSM encodings, rounding constants and the output clip helper.
package hevc_subpel_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam int ROUND = 32;
    localparam int SHIFT = 6;

    // Element [0] is tap 0, the leftmost pixel of the 8-pixel window.
    localparam logic signed [7:0] COEF_A [8] = '{-8'sd1, 8'sd4, -8'sd10, 8'sd58, 8'sd17, -8'sd5, 8'sd1, 8'sd0};
    localparam logic signed [7:0] COEF_B [8] = '{-8'sd1, 8'sd4, -8'sd11, 8'sd40, 8'sd40, -8'sd11, 8'sd4, -8'sd1};
    localparam logic signed [7:0] COEF_C [8] = '{8'sd0, 8'sd1, -8'sd5, 8'sd17, 8'sd58, -8'sd10, 8'sd4, -8'sd1};

    function automatic logic [15:0] clip_pix(input logic signed [31:0] v, input int pix_w);
        logic signed [31:0] maxv;
        maxv = (32'sd1 <<< pix_w) - 32'sd1;
        if (v < 32'sd0) begin
            clip_pix = '0;
        end else if (v > maxv) begin
            clip_pix = maxv[15:0];
        end else begin
            clip_pix = v[15:0];
        end
    endfunction

endpackage

// File: rtl/subpel_fir8.sv
// One output pixel: 8-tap window to quarter/half/three-quarter samples in two
// registered stages sharing one advance enable. SUBPEL_HI_PREC_EN selects raw output.
module subpel_fir8
    import hevc_subpel_pkg::*;
#(
    parameter int PIXEL_W = 8,
    parameter int OUT_W   = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 en_i,
    input  logic [8*PIXEL_W-1:0] win_i,
    output logic [OUT_W-1:0]     a_o,
    output logic [OUT_W-1:0]     b_o,
    output logic [OUT_W-1:0]     c_o
);
    localparam int SW = PIXEL_W + 8;

    logic signed [SW-1:0] pix_s [8];
    logic signed [SW-1:0] pa_q [8];
    logic signed [SW-1:0] pb_q [8];
    logic signed [SW-1:0] pc_q [8];
    logic signed [SW-1:0] sum_a, sum_b, sum_c;
    logic [OUT_W-1:0]     a_d, b_d, c_d;
    logic [OUT_W-1:0]     a_q, b_q, c_q;

    function automatic logic [OUT_W-1:0] finish_sum(input logic signed [SW-1:0] s);
`ifdef SUBPEL_HI_PREC_EN
        finish_sum = OUT_W'(s >>> (PIXEL_W - 8));
`else
        finish_sum = OUT_W'(clip_pix((32'(s) + ROUND) >>> SHIFT, PIXEL_W));
`endif
    endfunction

    always_comb begin
        for (int t = 0; t < 8; t++) begin
            pix_s[t] = SW'($signed({1'b0, win_i[t*PIXEL_W +: PIXEL_W]}));
        end
    end

    always_comb begin
        sum_a = '0;
        sum_b = '0;
        sum_c = '0;
        for (int t = 0; t < 8; t++) begin
            sum_a = sum_a + pa_q[t];
            sum_b = sum_b + pb_q[t];
            sum_c = sum_c + pc_q[t];
        end
        a_d = finish_sum(sum_a);
        b_d = finish_sum(sum_b);
        c_d = finish_sum(sum_c);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int t = 0; t < 8; t++) begin
                pa_q[t] <= '0;
                pb_q[t] <= '0;
                pc_q[t] <= '0;
            end
            a_q <= '0;
            b_q <= '0;
            c_q <= '0;
        end else if (en_i) begin
            for (int t = 0; t < 8; t++) begin
                pa_q[t] <= pix_s[t] * SW'(COEF_A[t]);
                pb_q[t] <= pix_s[t] * SW'(COEF_B[t]);
                pc_q[t] <= pix_s[t] * SW'(COEF_C[t]);
            end
            a_q <= a_d;
            b_q <= b_d;
            c_q <= c_d;
        end
    end

    assign a_o = a_q;
    assign b_o = b_q;
    assign c_o = c_q;

endmodule

// File: rtl/subpel_hfilter_engine.sv
// Horizontal HEVC luma sub-pel engine: block-framing FSM, row index tracking and
// valid/ready handshake around NUM_PIXEL subpel_fir8 lanes. Macro: SUBPEL_HI_PREC_EN.
module subpel_hfilter_engine
    import hevc_subpel_pkg::*;
#(
    parameter int NUM_PIXEL = 8,
    parameter int BLK_H     = 8,
    parameter int PIXEL_W   = 8,
`ifdef SUBPEL_HI_PREC_EN
    localparam int OUT_W    = 16
`else
    localparam int OUT_W    = PIXEL_W
`endif
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [(NUM_PIXEL+7)*PIXEL_W-1:0] in_row,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [NUM_PIXEL*OUT_W-1:0]     out_row_a,
    output logic [NUM_PIXEL*OUT_W-1:0]     out_row_b,
    output logic [NUM_PIXEL*OUT_W-1:0]     out_row_c,
    output logic [7:0]                     out_row_idx,
    output logic                           out_last,
    output logic                           busy,
    output logic                           done,
    output logic [1:0]                     dbg_state
);
    localparam logic [7:0] LAST_ROW = 8'(BLK_H + 6);

    state_t     state_q;
    logic [7:0] in_cnt_q;
    logic [7:0] idx1_q;
    logic [7:0] idx_q;
    logic       v1_q;
    logic       out_valid_q;
    logic       done_q;
    logic       en;
    logic       accept;
    logic       out_fire;

    // Handshake: a transfer happens on a rising edge where valid && ready are both
    // high; valid never depends on ready, and a stalled output holds every stage.
    assign en       = !out_valid_q || out_ready;
    assign in_ready = (state_q == S_LOAD) && en;
    assign accept   = in_valid && in_ready;
    assign out_fire = out_valid_q && out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            in_cnt_q    <= '0;
            idx1_q      <= '0;
            idx_q       <= '0;
            v1_q        <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (en) begin
                v1_q        <= accept;
                idx1_q      <= in_cnt_q;
                out_valid_q <= v1_q;
                idx_q       <= idx1_q;
            end
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q  <= S_LOAD;
                        in_cnt_q <= '0;
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        in_cnt_q <= in_cnt_q + 8'd1;
                        if (in_cnt_q == LAST_ROW) begin
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (out_fire && (idx_q == LAST_ROW)) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < NUM_PIXEL; i++) begin : g_px
        subpel_fir8 #(
            .PIXEL_W(PIXEL_W),
            .OUT_W  (OUT_W)
        ) u_fir (
            .clk_i (clk),
            .rst_ni(rst),
            .en_i  (en),
            .win_i (in_row[i*PIXEL_W +: 8*PIXEL_W]),
            .a_o   (out_row_a[i*OUT_W +: OUT_W]),
            .b_o   (out_row_b[i*OUT_W +: OUT_W]),
            .c_o   (out_row_c[i*OUT_W +: OUT_W])
        );
    end

    assign out_valid   = out_valid_q;
    assign out_row_idx = idx_q;
    assign out_last    = out_valid_q && (idx_q == LAST_ROW);
    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_subpel_hfilter_engine.sv
// Bench for subpel_hfilter_engine: reference filter model feeding an expected
// queue, a vector table for window corner cases, and handwritten stall/start/reset sequences.
module tb_subpel_hfilter_engine;
    localparam int NUM_PIXEL = 8;
    localparam int BLK_H     = 8;
    localparam int PIXEL_W   = 8;
`ifdef SUBPEL_HI_PREC_EN
    localparam int OUT_W     = 16;
`else
    localparam int OUT_W     = PIXEL_W;
`endif
    localparam int NPX_IN   = NUM_PIXEL + 7;
    localparam int ROW_W    = NPX_IN * PIXEL_W;
    localparam int RW       = NUM_PIXEL * OUT_W;
    localparam int ENT_W    = 3 * RW + 8;
    localparam int NROWS    = BLK_H + 7;
    localparam int LAST_IDX = BLK_H + 6;
    localparam int NVEC     = 6;

    localparam int CA [8] = '{-1, 4, -10, 58, 17, -5, 1, 0};
    localparam int CB [8] = '{-1, 4, -11, 40, 40, -11, 4, -1};
    localparam int CC [8] = '{0, 1, -5, 17, 58, -10, 4, -1};

    typedef struct {
        logic [8*PIXEL_W-1:0] win;
        int ea;
        int eb;
        int ec;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             in_valid;
    logic             in_ready;
    logic [ROW_W-1:0] in_row;
    logic             out_valid;
    logic             out_ready;
    logic [RW-1:0]    out_row_a, out_row_b, out_row_c;
    logic [7:0]       out_row_idx;
    logic             out_last;
    logic             busy;
    logic             done;
    logic [1:0]       dbg_state;

    logic [ENT_W-1:0] exp_q[$];
    logic [ENT_W-1:0] ent;
    vec_t             tbl [NVEC];
    int               n_chk = 0;
    int               n_fail = 0;
    int               row_cnt = 0;
    int               blk_outs = 0;
    bit               tbl_on = 1'b0;
    bit               last_hs_prev = 1'b0;
    bit               hs_last;

    subpel_hfilter_engine #(
        .NUM_PIXEL(NUM_PIXEL),
        .BLK_H    (BLK_H),
        .PIXEL_W  (PIXEL_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_row     (in_row),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_row_a  (out_row_a),
        .out_row_b  (out_row_b),
        .out_row_c  (out_row_c),
        .out_row_idx(out_row_idx),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [OUT_W-1:0] fin(input int s);
`ifdef SUBPEL_HI_PREC_EN
        return OUT_W'(s >>> (PIXEL_W - 8));
`else
        int v;
        v = (s + 32) >>> 6;
        if (v < 0) v = 0;
        if (v > 255) v = 255;
        return OUT_W'(v);
`endif
    endfunction

    function automatic int px0(input logic [OUT_W-1:0] x);
`ifdef SUBPEL_HI_PREC_EN
        return int'($signed(x));
`else
        return int'(x);
`endif
    endfunction

    function automatic logic [ENT_W-1:0] model(input logic [ROW_W-1:0] r, input int idx);
        logic [RW-1:0] a, b, c;
        int sa, sb, sc, p;
        for (int i = 0; i < NUM_PIXEL; i++) begin
            sa = 0; sb = 0; sc = 0;
            for (int t = 0; t < 8; t++) begin
                p  = int'(r[(i+t)*PIXEL_W +: PIXEL_W]);
                sa = sa + CA[t] * p;
                sb = sb + CB[t] * p;
                sc = sc + CC[t] * p;
            end
            a[i*OUT_W +: OUT_W] = fin(sa);
            b[i*OUT_W +: OUT_W] = fin(sb);
            c[i*OUT_W +: OUT_W] = fin(sc);
        end
        return {a, b, c, 8'(idx)};
    endfunction

    function automatic logic [ROW_W-1:0] make_row(input int kind, input int r);
        logic [ROW_W-1:0] v;
        for (int k = 0; k < NPX_IN; k++) begin
            v[k*PIXEL_W +: PIXEL_W] = (kind == 0) ? PIXEL_W'(100) : PIXEL_W'($urandom_range(0, 255));
        end
        if (kind == 1 && r < NVEC) v[8*PIXEL_W-1:0] = tbl[r].win;
        return v;
    endfunction

    // Scoreboard: push on input transfer, pop and compare on output transfer.
    always @(negedge clk) begin
        if (!rst) begin
            last_hs_prev = 1'b0;
        end else begin
            if (done || last_hs_prev) check("done_pulse", done, last_hs_prev);
            if (in_valid && in_ready) begin
                exp_q.push_back(model(in_row, row_cnt));
                row_cnt++;
            end
            hs_last = 1'b0;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_output: got idx %0d expected no output", out_row_idx);
                end else begin
                    ent = exp_q.pop_front();
                    check("row_a", out_row_a, ent[2*RW+8 +: RW]);
                    check("row_b", out_row_b, ent[RW+8 +: RW]);
                    check("row_c", out_row_c, ent[8 +: RW]);
                    check("row_idx", out_row_idx, ent[7:0]);
                    hs_last = (int'(ent[7:0]) == LAST_IDX);
                    check("out_last", out_last, hs_last);
                    if (tbl_on && int'(ent[7:0]) < NVEC) begin
                        check_int("tbl_a0", px0(out_row_a[OUT_W-1:0]), tbl[int'(ent[7:0])].ea);
                        check_int("tbl_b0", px0(out_row_b[OUT_W-1:0]), tbl[int'(ent[7:0])].eb);
                        check_int("tbl_c0", px0(out_row_c[OUT_W-1:0]), tbl[int'(ent[7:0])].ec);
                    end
                    blk_outs++;
                end
            end
            last_hs_prev = hs_last;
        end
    end

    task automatic start_block();
        start    = 1'b1;
        row_cnt  = 0;
        blk_outs = 0;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_row(input logic [ROW_W-1:0] r);
        int  guard = 0;
        bit  hs = 1'b0;
        in_row   = r;
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            hs = in_ready;
            @(posedge clk); #1;
            guard++;
        end while (!hs && guard < 200);
        if (!hs) check("send_row_timeout", 1'b0, 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic send_block(input int kind, input int start_at);
        for (int r = 0; r < NROWS; r++) begin
            if (r == start_at) start = 1'b1;
            send_row(make_row(kind, r));
            start = 1'b0;
        end
    endtask

    task automatic wait_done(input bit restart);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!done && k < 300);
        check("done_seen", done, 1'b1);
        check("idle_at_done", busy, 1'b0);
        if (restart) begin
            start    = 1'b1;
            row_cnt  = 0;
            blk_outs = 0;
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic stall_seq();
        logic [RW-1:0] sa, sb, sc;
        logic [7:0]    si;
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 0) begin
                check("stall_valid", out_valid, 1'b1);
                sa = out_row_a; sb = out_row_b; sc = out_row_c; si = out_row_idx;
            end else begin
                check("stall_hold_a", out_row_a, sa);
                check("stall_hold_b", out_row_b, sb);
                check("stall_hold_c", out_row_c, sc);
                check("stall_hold_idx", out_row_idx, si);
            end
            check("stall_in_ready", in_ready, 1'b0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
    endtask

    initial begin
        tbl[0] = '{win: {8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100}, ea: 0, eb: 0, ec: 0};
        tbl[1] = '{win: {8'd0, 8'd255, 8'd0, 8'd255, 8'd255, 8'd0, 8'd255, 8'd0}, ea: 0, eb: 0, ec: 0};
        tbl[2] = '{win: {8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd255, 8'd0, 8'd255}, ea: 0, eb: 0, ec: 0};
        tbl[3] = '{win: {8'd0, 8'd0, 8'd0, 8'd0, 8'd64, 8'd0, 8'd0, 8'd0}, ea: 0, eb: 0, ec: 0};
        tbl[4] = '{win: {8'd0, 8'd0, 8'd0, 8'd64, 8'd0, 8'd0, 8'd0, 8'd0}, ea: 0, eb: 0, ec: 0};
        tbl[5] = '{win: {8'd0, 8'd0, 8'd0, 8'd255, 8'd255, 8'd0, 8'd0, 8'd0}, ea: 0, eb: 0, ec: 0};
`ifdef SUBPEL_HI_PREC_EN
        tbl[0].ea = 6400;  tbl[0].eb = 6400;  tbl[0].ec = 6400;
        tbl[1].ea = 20400; tbl[1].eb = 22440; tbl[1].ec = 20400;
        tbl[2].ea = -4080; tbl[2].eb = -5865; tbl[2].ec = -3825;
        tbl[3].ea = 3712;  tbl[3].eb = 2560;  tbl[3].ec = 1088;
        tbl[4].ea = 1088;  tbl[4].eb = 2560;  tbl[4].ec = 3712;
        tbl[5].ea = 19125; tbl[5].eb = 20400; tbl[5].ec = 19125;
`else
        tbl[0].ea = 100; tbl[0].eb = 100; tbl[0].ec = 100;
        tbl[1].ea = 255; tbl[1].eb = 255; tbl[1].ec = 255;
        tbl[2].ea = 0;   tbl[2].eb = 0;   tbl[2].ec = 0;
        tbl[3].ea = 58;  tbl[3].eb = 40;  tbl[3].ec = 17;
        tbl[4].ea = 17;  tbl[4].eb = 40;  tbl[4].ec = 58;
        tbl[5].ea = 255; tbl[5].eb = 255; tbl[5].ec = 255;
`endif

        rst = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_row = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_row_a", out_row_a, '0);
        check("rst_idx", out_row_idx, 8'd0);
        check("rst_state", dbg_state, 2'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Flat block of 100s.
        start_block();
        send_block(0, -1);
        wait_done(1'b0);
        check_int("blk1_outputs", blk_outs, NROWS);

        // Table windows on rows 0..NVEC-1.
        start_block();
        tbl_on = 1'b1;
        send_block(1, -1);
        wait_done(1'b0);
        tbl_on = 1'b0;

        // Output stall mid-block with input still offered.
        start_block();
        fork
            send_block(2, -1);
            stall_seq();
        join
        wait_done(1'b0);
        check_int("stall_outputs", blk_outs, NROWS);

        // start during LOAD and DRAIN ignored; start during done restarts.
        start_block();
        send_block(2, 3);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("drain_busy", busy, 1'b1);
        wait_done(1'b1);
        @(negedge clk);
        check("restart_busy", busy, 1'b1);
        @(posedge clk); #1;
        send_block(2, -1);
        wait_done(1'b0);
        check_int("restart_outputs", blk_outs, NROWS);

        // Reset after row 6, then a full clean block.
        start_block();
        for (int r = 0; r < 7; r++) send_row(make_row(2, r));
        #1 rst = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_in_ready", in_ready, 1'b0);
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_last", out_last, 1'b0);
        check("mid_rst_row_a", out_row_a, '0);
        check("mid_rst_row_b", out_row_b, '0);
        check("mid_rst_row_c", out_row_c, '0);
        check("mid_rst_idx", out_row_idx, 8'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        start_block();
        tbl_on = 1'b1;
        send_block(1, -1);
        wait_done(1'b0);
        tbl_on = 1'b0;
        check_int("post_rst_outputs", blk_outs, NROWS);

        repeat (3) @(posedge clk);
        check_int("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
